// File: rtl/bcd_time_counter.sv
// MM:SS stopwatch/timer counter held as four BCD digits, with up/down counting,
// wrap or saturate at the count limit, and paused-mode digit adjustment.
module bcd_time_counter #(
  parameter int MAX_MIN = 99,
  parameter int WRAP    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       run,
  input  logic       dir,
  input  logic       clear,
  input  logic       adj_min,
  input  logic       adj_sec,
  output logic [3:0] min_l,
  output logic [3:0] min_r,
  output logic [3:0] sec_l,
  output logic [3:0] sec_r,
  output logic       limit,
  output logic       at_zero
);

  typedef struct packed {
    logic [3:0] min_l;
    logic [3:0] min_r;
    logic [3:0] sec_l;
    logic [3:0] sec_r;
  } bcd_time_t;

  localparam logic [3:0] MAX_L = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_R = 4'(MAX_MIN % 10);
  localparam bcd_time_t  ZERO  = '0;
  localparam bcd_time_t  TOP   = {MAX_L, MAX_R, 4'd5, 4'd9};

  bcd_time_t cur;
  bcd_time_t nxt;
  logic      nxt_limit;

  // Seconds field helpers wrap within 00..59 and never touch the minutes.
  function automatic bcd_time_t sec_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_r == 4'd9) begin
      r.sec_r = 4'd0;
      r.sec_l = (t.sec_l == 4'd5) ? 4'd0 : t.sec_l + 4'd1;
    end else begin
      r.sec_r = t.sec_r + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd_time_t sec_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_r == 4'd0) begin
      r.sec_r = 4'd9;
      r.sec_l = (t.sec_l == 4'd0) ? 4'd5 : t.sec_l - 4'd1;
    end else begin
      r.sec_r = t.sec_r - 4'd1;
    end
    return r;
  endfunction

  // Minutes field helpers wrap within 00..MAX_MIN and never touch the seconds.
  function automatic bcd_time_t min_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.min_l == MAX_L && t.min_r == MAX_R) begin
      r.min_l = 4'd0;
      r.min_r = 4'd0;
    end else if (t.min_r == 4'd9) begin
      r.min_r = 4'd0;
      r.min_l = t.min_l + 4'd1;
    end else begin
      r.min_r = t.min_r + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd_time_t min_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.min_l == 4'd0 && t.min_r == 4'd0) begin
      r.min_l = MAX_L;
      r.min_r = MAX_R;
    end else if (t.min_r == 4'd0) begin
      r.min_r = 4'd9;
      r.min_l = t.min_l - 4'd1;
    end else begin
      r.min_r = t.min_r - 4'd1;
    end
    return r;
  endfunction

  // Adjust only acts while paused and counting only while running, so the two
  // can never collide; clear overrides both.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    nxt       = cur;
    nxt_limit = 1'b0;
    if (clear) begin
      nxt = ZERO;
    end else if (!run) begin
      if (adj_sec) nxt = sec_inc(nxt);
      if (adj_min) nxt = min_inc(nxt);
    end else if (tick) begin
      if (!dir) begin
        if (cur == TOP) begin
          nxt_limit = 1'b1;
          if (WRAP != 0) nxt = ZERO;
        end else begin
          nxt = sec_inc(cur);
          if (cur.sec_l == 4'd5 && cur.sec_r == 4'd9) nxt = min_inc(nxt);
        end
      end else begin
        if (cur == ZERO) begin
          nxt_limit = 1'b1;
          if (WRAP != 0) nxt = TOP;
        end else begin
          nxt = sec_dec(cur);
          if (cur.sec_l == 4'd0 && cur.sec_r == 4'd0) nxt = min_dec(nxt);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      cur     <= ZERO;
      limit   <= 1'b0;
      at_zero <= 1'b1;
    end else begin
      cur     <= nxt;
      limit   <= nxt_limit;
      at_zero <= (nxt == ZERO);
    end
  end

  assign {min_l, min_r, sec_l, sec_r} = cur;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Four counter instances (different MAX_MIN/WRAP) share one stimulus stream and are
// compared every cycle against a seconds-as-integer reference model.
module tb_bcd_time_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, tick, run, dir, clear, adj_min, adj_sec;
  logic [3:0] min_l [4];
  logic [3:0] min_r [4];
  logic [3:0] sec_l [4];
  logic [3:0] sec_r [4];
  logic       limit [4];
  logic       at_zero [4];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: time as total seconds, plus the expected limit pulse.
  int mv [4];
  bit ml [4];

  bcd_time_counter #(.MAX_MIN(99), .WRAP(1)) u_d0 (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .dir(dir), .clear(clear),
    .adj_min(adj_min), .adj_sec(adj_sec), .min_l(min_l[0]), .min_r(min_r[0]),
    .sec_l(sec_l[0]), .sec_r(sec_r[0]), .limit(limit[0]), .at_zero(at_zero[0]));
  bcd_time_counter #(.MAX_MIN(99), .WRAP(0)) u_d1 (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .dir(dir), .clear(clear),
    .adj_min(adj_min), .adj_sec(adj_sec), .min_l(min_l[1]), .min_r(min_r[1]),
    .sec_l(sec_l[1]), .sec_r(sec_r[1]), .limit(limit[1]), .at_zero(at_zero[1]));
  bcd_time_counter #(.MAX_MIN(59), .WRAP(1)) u_d2 (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .dir(dir), .clear(clear),
    .adj_min(adj_min), .adj_sec(adj_sec), .min_l(min_l[2]), .min_r(min_r[2]),
    .sec_l(sec_l[2]), .sec_r(sec_r[2]), .limit(limit[2]), .at_zero(at_zero[2]));
  bcd_time_counter #(.MAX_MIN(5), .WRAP(1)) u_d3 (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .dir(dir), .clear(clear),
    .adj_min(adj_min), .adj_sec(adj_sec), .min_l(min_l[3]), .min_r(min_r[3]),
    .sec_l(sec_l[3]), .sec_r(sec_r[3]), .limit(limit[3]), .at_zero(at_zero[3]));

  function automatic int max_of(input int i);
    case (i)
      2:       return 59;
      3:       return 5;
      default: return 99;
    endcase
  endfunction

  function automatic bit wrap_of(input int i);
    return i != 1;
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] obs(input int i);
    return {min_l[i], min_r[i], sec_l[i], sec_r[i]};
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    int m, s;
    m = v / 60;
    s = v % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_step(input int i);
    int top, m, s;
    top   = max_of(i) * 60 + 59;
    ml[i] = 1'b0;
    if (rst || clear) begin
      mv[i] = 0;
    end else if (!run) begin
      m = mv[i] / 60;
      s = mv[i] % 60;
      if (adj_sec) s = (s + 1) % 60;
      if (adj_min) m = (m + 1) % (max_of(i) + 1);
      mv[i] = m * 60 + s;
    end else if (tick) begin
      if (!dir) begin
        if (mv[i] == top) begin
          ml[i] = 1'b1;
          if (wrap_of(i)) mv[i] = 0;
        end else begin
          mv[i] = mv[i] + 1;
        end
      end else begin
        if (mv[i] == 0) begin
          ml[i] = 1'b1;
          if (wrap_of(i)) mv[i] = top;
        end else begin
          mv[i] = mv[i] - 1;
        end
      end
    end
  endtask

  // One clock: advance every model with the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 4; i++) model_step(i);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("d%0d time", i), obs(i), to_bcd(mv[i]));
      check($sformatf("d%0d limit", i), {15'b0, limit[i]}, {15'b0, ml[i]});
      check($sformatf("d%0d at_zero", i), {15'b0, at_zero[i]}, {15'b0, mv[i] == 0});
    end
    check("d3 min_l", {12'b0, min_l[3]}, 16'h0000);
  endtask

  task automatic drive(input logic t, input logic rn, input logic d, input logic cl,
                       input logic am, input logic as, input logic rs);
    tick = t; run = rn; dir = d; clear = cl; adj_min = am; adj_sec = as; rst = rs;
    step();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_dut(input int i, input string tag, input logic [15:0] digits,
                           input logic lim, input logic zero);
    check($sformatf("%s d%0d time", tag, i), obs(i), digits);
    check($sformatf("%s d%0d limit", tag, i), {15'b0, limit[i]}, {15'b0, lim});
    check($sformatf("%s d%0d at_zero", tag, i), {15'b0, at_zero[i]}, {15'b0, zero});
  endtask

  // Paused preset from 00:00 using separated adjust pulses.
  task automatic preset(input int mins, input int secs);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < ((mins > secs) ? mins : secs); k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, k < mins, k < secs, 1'b0);
      idle();
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mv[i] = 0;
      ml[i] = 1'b0;
    end
    tick = 0; run = 0; dir = 0; clear = 0; adj_min = 0; adj_sec = 0; rst = 1;

    // Reset with a tick and adjust present: reset still wins.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) check_dut(i, "reset", 16'h0000, 1'b0, 1'b1);

    // Full up-count to 99:59 then rollover (d1 saturates instead).
    repeat (5999) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_dut(0, "up 5999", 16'h9959, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_dut(0, "up rollover", 16'h0000, 1'b1, 1'b1);
    check_dut(1, "up saturate", 16'h9959, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_dut(0, "limit one cycle", 16'h0000, 1'b0, 1'b1);

    // Down-count saturation on d1 from 00:02.
    preset(0, 2);
    check_dut(1, "preset 00:02", 16'h0002, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_dut(1, "down 1", 16'h0001, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_dut(1, "down 2", 16'h0000, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_dut(1, "down hold", 16'h0000, 1'b1, 1'b1);
    check_dut(0, "down wrap", 16'h9959, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_dut(1, "down hold again", 16'h0000, 1'b1, 1'b1);

    // Adjust wrap on d2 (MAX_MIN=59); simultaneous adjusts during the preset.
    preset(59, 59);
    check_dut(2, "preset 59:59", 16'h5959, 1'b0, 1'b0);
    check_dut(3, "preset mod 6", 16'h0559, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_dut(2, "adj_sec wrap", 16'h5900, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_dut(2, "adj_min wrap", 16'h0000, 1'b0, 1'b1);
    check_dut(0, "adj_min no wrap", 16'h6000, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_dut(0, "adj ignored run", 16'h6000, 1'b0, 1'b0);

    // MAX_MIN=5 rollover from 05:59.
    preset(5, 59);
    check_dut(3, "preset 05:59", 16'h0559, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_dut(3, "max5 rollover", 16'h0000, 1'b1, 1'b1);

    // Priority: clear and reset both discard a coincident tick.
    preset(12, 34);
    check_dut(0, "preset 12:34", 16'h1234, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_dut(0, "tick+clear", 16'h0000, 1'b0, 1'b1);
    preset(12, 34);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_dut(0, "tick+rst", 16'h0000, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_dut(1, "rst beats limit", 16'h0000, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_dut(1, "clear beats limit", 16'h0000, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_dut(0, "resume after rst", 16'h0001, 1'b0, 1'b0);

    // Direction change with no hidden state.
    preset(10, 0);
    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_dut(0, "up 3", 16'h1003, 1'b0, 1'b0);
    repeat (4) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_dut(0, "down 4", 16'h0959, 1'b0, 1'b0);

    // Randomized traffic, checked every cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
            $urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 99) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_time_counter.md
BCD_TIME_COUNTER -- requirements
Module: bcd_time_counter

Interface
REQ-001 Parameter MAX_MIN, default 99: highest minutes value; legal range 1..99.
REQ-002 Parameter WRAP, default 1: 1 = wrap at count limit; 0 = saturate at count limit.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 tick  in  1  one-cycle count strobe, for example 1 Hz from the prescaler.
REQ-006 run  in  1  1 = counting enabled; 0 = paused.
REQ-007 dir  in  1  0 = count up; 1 = count down.
REQ-008 clear  in  1  synchronous clear of the time value.
REQ-009 adj_min  in  1  while paused, one-cycle pulse adds 1 to the minutes field.
REQ-010 adj_sec  in  1  while paused, one-cycle pulse adds 1 to the seconds field.
REQ-011 min_l, min_r, sec_l, sec_r  out  4 each  registered BCD digits of MM:SS.
REQ-012 limit  out  1  one-cycle pulse when a counted tick hits the count limit.
REQ-013 at_zero  out  1  registered level; 1 when the value is 00:00.

Function
REQ-014 Counting: a tick with run=1 and adjust inactive moves the value by exactly one second, in the direction set by dir; the outputs update on the same edge.
REQ-015 Inputs with no effect: tick with run=0 does nothing; no output changes without tick, clear, adj_* or rst.
REQ-016 Up-count digit rules:
  - sec_r wraps 9 to 0 and carries into sec_l.
  - sec_l wraps 5 to 0 and carries into minutes.
  - min_r wraps 9 to 0 and carries into min_l.
REQ-017 Down-count digit rules: the mirror of REQ-016; a borrow from 00 seconds gives 59 seconds and decrements minutes.
REQ-018 Up-count limit is MAX_MIN:59; down-count limit is 00:00.
REQ-019 A tick at the limit with WRAP=1:
  - up: value becomes 00:00.
  - down: value becomes MAX_MIN:59.
  - limit pulses high for that cycle.
REQ-020 A tick at the limit with WRAP=0: value holds and limit pulses high for that cycle.
REQ-021 limit stays high for exactly one cycle per qualifying tick and is never asserted otherwise.
REQ-022 Adjust applies only when run=0; adj_min and adj_sec are ignored while run=1.
REQ-023 adj_sec increments seconds modulo 60 with no carry into minutes.
REQ-024 adj_min increments minutes modulo (MAX_MIN+1) with no carry.
REQ-025 adj_min and adj_sec asserted together both apply on the same edge.
REQ-026 Adjust pulses never assert limit.
REQ-027 Priority on a single edge: rst > clear > adjust > tick; a lower-priority event in the same cycle is discarded, not deferred.
REQ-028 Changing dir between ticks takes effect on the next tick; there is no hidden state.
REQ-029 at_zero is computed from the next-state value so that it is coincident with the digit outputs.
REQ-030 Every digit output always holds a legal BCD value:
  - sec_l never exceeds 5.
  - the minutes value never exceeds MAX_MIN.
REQ-031 MAX_MIN < 10 forces min_l to 0 at all times.

Reset
REQ-032 rst=1 at a clock edge sets all digits to 0, limit=0 and at_zero=1, regardless of any other input.
REQ-033 clear=1 has the same effect on the digits and at_zero; limit is 0 that cycle.
REQ-034 Reset asserted mid-count: the tick in the same cycle is discarded; counting resumes from 00:00 on the first tick after rst deasserts.
REQ-035 No reset value depends on parameters.

Verification
REQ-036 Up-count rollover, MAX_MIN=99, WRAP=1: run=1, dir=0, 5999 ticks from reset -> 99:59 with at_zero=0 -> one more tick gives 00:00, limit=1 for one cycle, at_zero=1.
REQ-037 Down-count saturation, WRAP=0: preset 00:02 via adjust, run=1, dir=1 -> 00:01, then 00:00 with at_zero=1 -> third tick holds 00:00 with limit=1 -> fourth tick gives limit=1 again.
REQ-038 Adjust, MAX_MIN=59: run=0 at 59:59 -> adj_sec gives 59:00 -> adj_min gives 00:00, limit never asserted -> adj_sec with run=1 leaves the value unchanged.
REQ-039 Priority: from 12:34, tick and clear together -> 00:00 -> tick and rst together -> 00:00 with limit=0.
REQ-040 Direction change: from 10:00 up-count 3 ticks -> 10:03 -> dir=1 and 4 ticks -> 09:59.
REQ-041 Parameter check, MAX_MIN=5: up-count from 05:59 -> 00:00 with limit=1; min_l=0 throughout.
